// File: rtl/renode_apb4_pkg.sv
// Shared types and helpers for the renode APB4 requester.
package renode_apb4_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    // PPROT bit meanings
    localparam logic [2:0] PPROT_PRIVILEGED  = 3'b001;
    localparam logic [2:0] PPROT_NONSECURE   = 3'b010;
    localparam logic [2:0] PPROT_INSTRUCTION = 3'b100;

    localparam int unsigned ProtWidth = 3;

    // Queued request payload: {write, addr, wdata, strb, prot}
    function automatic int unsigned req_width(input int unsigned aw, input int unsigned dw);
        return 1 + aw + dw + dw / 8 + ProtWidth;
    endfunction

    // Queued response payload: {rdata, error, timeout}
    function automatic int unsigned rsp_width(input int unsigned dw);
        return dw + 2;
    endfunction

endpackage

// File: rtl/renode_sync_fifo.sv
// Synchronous FIFO with registered storage and registered full/empty flags.
// A push is accepted while full when a pop happens in the same cycle.
module renode_sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PtrWidth = $clog2(Depth);

    logic [Width-1:0]    mem [Depth];
    logic [PtrWidth-1:0] wptr;
    logic [PtrWidth-1:0] rptr;
    logic [PtrWidth:0]   count;
    logic [PtrWidth:0]   count_next_c;
    logic                push_en_c;
    logic                pop_en_c;

    assign rdata = mem[rptr];

    // Qualify push/pop and compute the next occupancy
    always_comb begin
        push_en_c    = push && (!full || pop);
        pop_en_c     = pop && !empty;
        count_next_c = count;
        if (push_en_c && !pop_en_c) begin
            count_next_c = count + (PtrWidth + 1)'(1);
        end else if (!push_en_c && pop_en_c) begin
            count_next_c = count - (PtrWidth + 1)'(1);
        end
    end

    // Storage, pointers and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (push_en_c) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + PtrWidth'(1);
            end
            if (pop_en_c) begin
                rptr <= rptr + PtrWidth'(1);
            end
            count <= count_next_c;
            full  <= (count_next_c == (PtrWidth + 1)'(Depth));
            empty <= (count_next_c == '0);
        end
    end

endmodule

// File: rtl/renode_apb4_requester.sv
// APB4 requester: queued valid/ready requests in, in-order responses out.
// Optional wait-state timeout enabled by defining RENODE_APB4_REQUESTER_TIMEOUT_EN.
module renode_apb4_requester
    import renode_apb4_pkg::*;
#(
    parameter int unsigned AddressWidth  = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned FifoDepth     = 4,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [AddressWidth-1:0]   req_addr,
    input  logic [DataWidth-1:0]      req_wdata,
    input  logic [DataWidth/8-1:0]    req_strb,
    input  logic [2:0]                req_prot,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DataWidth-1:0]      rsp_rdata,
    output logic                      rsp_error,
    output logic                      rsp_timeout,
    output logic [AddressWidth-1:0]   paddr,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [DataWidth-1:0]      pwdata,
    output logic [DataWidth/8-1:0]    pstrb,
    output logic [2:0]                pprot,
    input  logic                      pready,
    input  logic [DataWidth-1:0]      prdata,
    input  logic                      pslverr
);
    localparam int unsigned ReqWidth    = req_width(AddressWidth, DataWidth);
    localparam int unsigned RspWidth    = rsp_width(DataWidth);
    localparam int unsigned CreditWidth = $clog2(FifoDepth + 1);

    state_t                   state;
    logic [CreditWidth-1:0]   credits;
    logic [CreditWidth-1:0]   credits_next_c;
    logic                     req_accept_c;
    logic                     rsp_pop_c;
    logic                     req_pop_c;
    logic                     rsp_push_c;
    logic                     tmo_hit_c;
    logic [ReqWidth-1:0]      req_head;
    logic [RspWidth-1:0]      rsp_in_c;
    logic [RspWidth-1:0]      rsp_head;
    logic                     req_empty;
    logic                     rsp_empty;
    logic                     req_full_unused;
    logic                     rsp_full_unused;
    logic                     rsp_head_tmo;
    logic                     head_write;
    logic [AddressWidth-1:0]  head_addr;
    logic [DataWidth-1:0]     head_wdata;
    logic [DataWidth/8-1:0]   head_strb;
    logic [2:0]               head_prot;

    assign req_accept_c = req_valid && req_ready;
    assign rsp_pop_c    = rsp_valid && rsp_ready;
    assign rsp_valid    = !rsp_empty;
    assign {head_write, head_addr, head_wdata, head_strb, head_prot} = req_head;
    assign {rsp_rdata, rsp_error, rsp_head_tmo} = rsp_head;

    // Pop into the issue registers from IDLE, or back-to-back on a completing ACCESS
    assign req_pop_c  = !req_empty && ((state == S_IDLE) || (state == S_ACCESS && pready));
    assign rsp_push_c = (state == S_ACCESS) && (pready || tmo_hit_c);
    assign rsp_in_c   = {(pready && !pwrite) ? prdata : DataWidth'(0),
                         pready ? pslverr : 1'b1,
                         !pready};

    renode_sync_fifo #(.Width(ReqWidth), .Depth(FifoDepth)) u_req_fifo (
        .clk   (pclk),
        .rst   (preset),
        .push  (req_accept_c),
        .wdata ({req_write, req_addr, req_wdata, req_strb, req_prot}),
        .pop   (req_pop_c),
        .rdata (req_head),
        .full  (req_full_unused),
        .empty (req_empty)
    );

    renode_sync_fifo #(.Width(RspWidth), .Depth(FifoDepth)) u_rsp_fifo (
        .clk   (pclk),
        .rst   (preset),
        .push  (rsp_push_c),
        .wdata (rsp_in_c),
        .pop   (rsp_ready),
        .rdata (rsp_head),
        .full  (rsp_full_unused),
        .empty (rsp_empty)
    );

    // Credits bound requests in flight so the response queue cannot overflow
    always_comb begin
        credits_next_c = credits;
        if (req_accept_c && !rsp_pop_c) begin
            credits_next_c = credits - CreditWidth'(1);
        end else if (!req_accept_c && rsp_pop_c) begin
            credits_next_c = credits + CreditWidth'(1);
        end
    end

    // Credit counter and registered request-ready
    always_ff @(posedge pclk) begin
        if (preset) begin
            credits   <= CreditWidth'(FifoDepth);
            req_ready <= 1'b1;
        end else begin
            credits   <= credits_next_c;
            req_ready <= (credits_next_c != '0);
        end
    end

`ifdef RENODE_APB4_REQUESTER_TIMEOUT_EN
    localparam int unsigned TmoWidth = $clog2(TimeoutCycles + 1);

    logic [TmoWidth-1:0] tmo_cnt;

    assign tmo_hit_c   = (state == S_ACCESS) && !pready &&
                         (tmo_cnt == TmoWidth'(TimeoutCycles - 1));
    assign rsp_timeout = rsp_head_tmo;

    // Wait-state counter, restarted on every SETUP
    always_ff @(posedge pclk) begin
        if (preset || state == S_SETUP) begin
            tmo_cnt <= '0;
        end else if (state == S_ACCESS && !pready) begin
            tmo_cnt <= tmo_cnt + TmoWidth'(1);
        end
    end
`else
    logic unused_tmo;

    assign tmo_hit_c   = 1'b0;
    assign rsp_timeout = 1'b0;
    assign unused_tmo  = rsp_head_tmo ^ (|TimeoutCycles);
`endif

    // APB transfer FSM; issue registers double as the APB outputs
    always_ff @(posedge pclk) begin
        if (preset) begin
            state   <= S_IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
            pstrb   <= '0;
            pprot   <= '0;
        end else begin
            case (state)
                S_SETUP: begin
                    penable <= 1'b1;
                    state   <= S_ACCESS;
                end
                default: begin
                    if (req_pop_c) begin
                        state   <= S_SETUP;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        pwrite  <= head_write;
                        paddr   <= head_addr;
                        pwdata  <= head_write ? head_wdata : DataWidth'(0);
                        pstrb   <= head_write ? head_strb : (DataWidth / 8)'(0);
                        pprot   <= head_prot;
                    end else if (state != S_ACCESS || pready || tmo_hit_c) begin
                        state   <= S_IDLE;
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        pwrite  <= 1'b0;
                        paddr   <= '0;
                        pwdata  <= '0;
                        pstrb   <= '0;
                        pprot   <= '0;
                    end
                end
            endcase
        end
    end

endmodule
